// File: rtl/dcache_mem_stage.sv
// Direct-mapped write-back, write-allocate data cache between the ALU and writeback stages.
// Optional hit/miss counters are compiled in when DCACHE_STATS_EN is defined.
module dcache_mem_stage #(
    parameter int unsigned ARCH_BITS        = 32,
    parameter int unsigned MEMORY_LINE_BITS = 128,
    parameter int unsigned LINES            = 4,
    parameter int unsigned INDEX_BITS       = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reqValid,
    input  logic                        reqWrite,
    input  logic                        reqByte,
    input  logic [ARCH_BITS-1:0]        reqAddr,
    input  logic [ARCH_BITS-1:0]        reqWData,
    output logic [ARCH_BITS-1:0]        rData,
    output logic                        rDataValid,
    output logic                        stall,
    output logic [ARCH_BITS-1:0]        memReadAddr,
    output logic                        memReadReq,
    input  logic [MEMORY_LINE_BITS-1:0] memData,
    input  logic                        memDataValid,
    output logic [ARCH_BITS-1:0]        memWriteAddr,
    output logic [MEMORY_LINE_BITS-1:0] memWriteData,
    output logic                        memWriteReq,
    input  logic                        memWriteDone,
    output logic [31:0]                 hitCount,
    output logic [31:0]                 missCount
);
    localparam int unsigned OffBits = 4;
    localparam int unsigned TagBits = ARCH_BITS - OffBits - INDEX_BITS;

    typedef enum logic [1:0] {StIdle, StWriteback, StRefill} state_e;

    state_e                      state_q;
    logic                        valid_q [LINES];
    logic                        dirty_q [LINES];
    logic [TagBits-1:0]          tag_q   [LINES];
    logic [MEMORY_LINE_BITS-1:0] data_q  [LINES];
    logic [INDEX_BITS-1:0]       miss_idx_q;
    logic [TagBits-1:0]          miss_tag_q;
    logic                        mem_read_req_q, mem_write_req_q;
    logic [ARCH_BITS-1:0]        mem_read_addr_q, mem_write_addr_q;
    logic [MEMORY_LINE_BITS-1:0] mem_write_data_q;

    logic [INDEX_BITS-1:0]       idx;
    logic [TagBits-1:0]          tag;
    logic                        hit, miss;
    logic [6:0]                  word_off, byte_off;
    logic [MEMORY_LINE_BITS-1:0] cur_line, store_line;

    assign idx      = reqAddr[OffBits +: INDEX_BITS];
    assign tag      = reqAddr[ARCH_BITS-1 -: TagBits];
    assign word_off = {reqAddr[3:2], 5'b0};
    assign byte_off = {reqAddr[3:0], 3'b0};
    assign cur_line = data_q[idx];

    // Lookups only happen in IDLE; any other state is already stalling the pipe.
    assign hit  = (state_q == StIdle) && reqValid && valid_q[idx] && (tag_q[idx] == tag);
    assign miss = (state_q == StIdle) && reqValid && !hit;

    assign rDataValid = hit;
    assign stall      = (state_q != StIdle) || miss;

    always_comb begin
        rData      = '0;
        store_line = cur_line;
        if (hit && !reqWrite) begin
            rData = reqByte ? {{(ARCH_BITS-8){1'b0}}, cur_line[byte_off +: 8]}
                            : cur_line[word_off +: ARCH_BITS];
        end
        if (reqByte) begin
            store_line[byte_off +: 8] = reqWData[7:0];
        end else begin
            store_line[word_off +: ARCH_BITS] = reqWData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            miss_idx_q       <= '0;
            miss_tag_q       <= '0;
            mem_read_req_q   <= 1'b0;
            mem_write_req_q  <= 1'b0;
            mem_read_addr_q  <= '0;
            mem_write_addr_q <= '0;
            mem_write_data_q <= '0;
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (hit && reqWrite) begin
                        data_q[idx]  <= store_line;
                        dirty_q[idx] <= 1'b1;
                    end else if (miss) begin
                        miss_idx_q      <= idx;
                        miss_tag_q      <= tag;
                        mem_read_addr_q <= {tag, idx, 4'b0};
                        if (valid_q[idx] && dirty_q[idx]) begin
                            mem_write_addr_q <= {tag_q[idx], idx, 4'b0};
                            mem_write_data_q <= cur_line;
                            mem_write_req_q  <= 1'b1;
                            state_q          <= StWriteback;
                        end else begin
                            mem_read_req_q <= 1'b1;
                            state_q        <= StRefill;
                        end
                    end
                end
                StWriteback: begin
                    if (memWriteDone) begin
                        dirty_q[miss_idx_q] <= 1'b0;
                        mem_write_req_q     <= 1'b0;
                        mem_read_req_q      <= 1'b1;
                        state_q             <= StRefill;
                    end
                end
                StRefill: begin
                    // Uses the captured miss index/tag so a flushed request still installs.
                    if (memDataValid) begin
                        data_q[miss_idx_q]  <= memData;
                        valid_q[miss_idx_q] <= 1'b1;
                        dirty_q[miss_idx_q] <= 1'b0;
                        tag_q[miss_idx_q]   <= miss_tag_q;
                        mem_read_req_q      <= 1'b0;
                        state_q             <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign memReadReq   = mem_read_req_q;
    assign memWriteReq  = mem_write_req_q;
    assign memReadAddr  = mem_read_addr_q;
    assign memWriteAddr = mem_write_addr_q;
    assign memWriteData = mem_write_data_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hitCount  = hit_cnt_q;
    assign missCount = miss_cnt_q;
`else
    assign hitCount  = '0;
    assign missCount = '0;
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// Self-checking bench for dcache_mem_stage: flat reference memory model, line-memory responder
// and a scoreboard of expected load results.
module tb_dcache_mem_stage;
    localparam int RdLat = 3;
    localparam int WbLat = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         reqValid, reqWrite, reqByte;
    logic [31:0]  reqAddr, reqWData;
    logic [31:0]  rData;
    logic         rDataValid, stall;
    logic [31:0]  memReadAddr, memWriteAddr;
    logic         memReadReq, memWriteReq;
    logic [127:0] memData, memWriteData;
    logic         memDataValid, memWriteDone;
    logic [31:0]  hitCount, missCount;

    dcache_mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .reqValid     (reqValid),
        .reqWrite     (reqWrite),
        .reqByte      (reqByte),
        .reqAddr      (reqAddr),
        .reqWData     (reqWData),
        .rData        (rData),
        .rDataValid   (rDataValid),
        .stall        (stall),
        .memReadAddr  (memReadAddr),
        .memReadReq   (memReadReq),
        .memData      (memData),
        .memDataValid (memDataValid),
        .memWriteAddr (memWriteAddr),
        .memWriteData (memWriteData),
        .memWriteReq  (memWriteReq),
        .memWriteDone (memWriteDone),
        .hitCount     (hitCount),
        .missCount    (missCount)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bk_mem  [int unsigned];
    int exp_hits = 0;
    int exp_misses = 0;
    bit overlap_seen = 1'b0;
    bit resp_en = 1'b1;
    bit inject_stray = 1'b0;
    logic [31:0]  last_wb_addr = '0;
    logic [127:0] last_wb_data = '0;

    typedef struct {
        logic        w;
        logic        b;
        logic [31:0] a;
        logic [31:0] wd;
        int          stalls;
    } vec_t;

    function automatic vec_t mkv(input logic w, input logic b, input logic [31:0] a,
                                 input logic [31:0] wd, input int stalls);
        vec_t v;
        v.w = w; v.b = b; v.a = a; v.wd = wd; v.stalls = stalls;
        return v;
    endfunction

    // Initial memory image: line 0x100 holds 0x44444444_33333333_22222222_11111111.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        logic [7:0]  b;
        logic [31:0] lb;
        b  = 8'h11 * {6'b0, a[3:2]} + 8'h11;
        lb = {4'h0, a[31:4]} ^ 32'h10;
        return {4{b}} ^ (lb << 8);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        int unsigned k;
        k = a >> 2;
        if (ref_mem.exists(k)) return ref_mem[k];
        return init_word({a[31:2], 2'b0});
    endfunction

    function automatic logic [127:0] ref_line(input logic [31:0] a);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_rd({a[31:4], 4'b0} + 32'(w * 4));
        return l;
    endfunction

    function automatic logic [127:0] bk_line(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  wa;
        for (int w = 0; w < 4; w++) begin
            wa = {a[31:4], 4'b0} + 32'(w * 4);
            l[w*32 +: 32] = bk_mem.exists(wa >> 2) ? bk_mem[wa >> 2] : init_word(wa);
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line-memory responder, driven on the falling edge to stay clear of the DUT's sampling edge.
    int rcnt = 0;
    int wcnt = 0;
    always @(negedge clk) begin
        memDataValid = 1'b0;
        memWriteDone = 1'b0;
        if (memReadReq && memWriteReq) overlap_seen = 1'b1;
        if (!rst) begin
            rcnt = 0;
            wcnt = 0;
        end else if (inject_stray) begin
            memDataValid = 1'b1;
            memWriteDone = 1'b1;
            memData      = '1;
        end else begin
            if (memWriteReq) begin
                wcnt++;
                if (wcnt == WbLat) begin
                    wcnt = 0;
                    memWriteDone = 1'b1;
                    chk("wb_data", memWriteData, ref_line(memWriteAddr));
                    last_wb_addr = memWriteAddr;
                    last_wb_data = memWriteData;
                    for (int w = 0; w < 4; w++)
                        bk_mem[(memWriteAddr >> 2) + 32'(w)] = memWriteData[w*32 +: 32];
                end
            end
            if (memReadReq && resp_en) begin
                rcnt++;
                if (rcnt == RdLat) begin
                    rcnt = 0;
                    memDataValid = 1'b1;
                    memData      = bk_line(memReadAddr);
                end
            end
        end
    end

    task automatic do_op(input logic w, input logic b, input logic [31:0] a, input logic [31:0] wd,
                         input int exp_stall, input string name, output logic [31:0] got);
        logic [31:0] word, e;
        int stalls;
        bit done;
        word = ref_rd(a);
        if (w) begin
            if (b) word[{a[1:0], 3'b0} +: 8] = wd[7:0];
            else word = wd;
            ref_mem[a >> 2] = word;
            e = '0;
        end else begin
            e = b ? {24'b0, word[{a[1:0], 3'b0} +: 8]} : word;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reqValid = 1'b1; reqWrite = w; reqByte = b; reqAddr = a; reqWData = wd;
        stalls = 0;
        done = 1'b0;
        got = '0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
                got = rData;
                chk({name, "_valid"}, 128'(rDataValid), 128'(1'b1));
                chk({name, "_rdata"}, 128'(rData), 128'(exp_q.pop_front()));
            end else begin
                stalls++;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: stall still high after 64 cycles", name);
            void'(exp_q.pop_front());
        end
        chk({name, "_stalls"}, 128'(stalls), 128'(exp_stall));
        exp_hits++;
        if (stalls > 0) exp_misses++;
        @(posedge clk);
        #1;
        reqValid = 1'b0; reqWrite = 1'b0; reqByte = 1'b0;
    endtask

    vec_t tbl [17];
    logic [31:0] got;
    int fl_stalls;

    initial begin
        rst = 1'b0;
        reqValid = 1'b0; reqWrite = 1'b0; reqByte = 1'b0; reqAddr = '0; reqWData = '0;
        memData = '0; memDataValid = 1'b0; memWriteDone = 1'b0;

        tbl[0]  = mkv(1'b0, 1'b0, 32'h104,  32'h0,        0);
        tbl[1]  = mkv(1'b1, 1'b0, 32'h108,  32'hDEADBEEF, 0);
        tbl[2]  = mkv(1'b0, 1'b0, 32'h108,  32'h0,        0);
        tbl[3]  = mkv(1'b1, 1'b1, 32'h113,  32'hFFFFFF5C, 0);
        tbl[4]  = mkv(1'b0, 1'b1, 32'h113,  32'h0,        0);
        tbl[5]  = mkv(1'b0, 1'b0, 32'h120,  32'h0,        1 + RdLat);
        tbl[6]  = mkv(1'b1, 1'b0, 32'h130,  32'h12345678, 1 + RdLat);
        tbl[7]  = mkv(1'b0, 1'b0, 32'h130,  32'h0,        0);
        tbl[8]  = mkv(1'b0, 1'b0, 32'h1300, 32'h0,        1 + WbLat + RdLat);
        tbl[9]  = mkv(1'b0, 1'b0, 32'h108,  32'h0,        1 + RdLat);
        tbl[10] = mkv(1'b0, 1'b0, 32'h330,  32'h0,        1 + WbLat + RdLat);
        tbl[11] = mkv(1'b0, 1'b1, 32'h131,  32'h0,        1 + RdLat);
        tbl[12] = mkv(1'b0, 1'b1, 32'h113,  32'h0,        0);
        tbl[13] = mkv(1'b1, 1'b1, 32'h1F3,  32'h77,       1 + RdLat);
        tbl[14] = mkv(1'b1, 1'b0, 32'h000,  32'hFFFFFFFF, 1 + RdLat);
        tbl[15] = mkv(1'b0, 1'b0, 32'h100,  32'h0,        1 + WbLat + RdLat);
        tbl[16] = mkv(1'b0, 1'b1, 32'h10B,  32'h0,        0);

        repeat (2) @(negedge clk);
        chk("rst_stall", 128'(stall), 128'(1'b0));
        chk("rst_rvalid", 128'(rDataValid), 128'(1'b0));
        chk("rst_rdata", 128'(rData), 128'(32'h0));
        chk("rst_rreq", 128'(memReadReq), 128'(1'b0));
        chk("rst_wreq", 128'(memWriteReq), 128'(1'b0));
        chk("rst_raddr", 128'(memReadAddr), 128'(32'h0));
        chk("rst_waddr", 128'(memWriteAddr), 128'(32'h0));
        chk("rst_wdata", memWriteData, 128'h0);
        chk("rst_hits", 128'(hitCount), 128'(32'h0));
        chk("rst_misses", 128'(missCount), 128'(32'h0));
        rst = 1'b1;

        do_op(1'b0, 1'b0, 32'h100, 32'h0, 1 + RdLat, "ldw_100", got);
        chk("ldw_100_const", 128'(got), 128'(32'h11111111));
        chk("refill_addr", 128'(memReadAddr), 128'(32'h100));
        do_op(1'b0, 1'b1, 32'h106, 32'h0, 0, "ldb_106", got);
        chk("ldb_106_const", 128'(got), 128'(32'h00000022));
        do_op(1'b1, 1'b1, 32'h105, 32'hAB, 0, "stb_105", got);
        do_op(1'b0, 1'b0, 32'h104, 32'h0, 0, "ldw_104", got);
        chk("ldw_104_const", 128'(got), 128'(32'h2222AB22));
        do_op(1'b0, 1'b0, 32'h140, 32'h0, 1 + WbLat + RdLat, "ldw_140", got);
        chk("evict_addr", 128'(last_wb_addr), 128'(32'h100));
        chk("evict_word1", 128'(last_wb_data[63:32]), 128'(32'h2222AB22));
        chk("refill_addr_140", 128'(memReadAddr), 128'(32'h140));
        do_op(1'b0, 1'b0, 32'h110, 32'h0, 1 + RdLat, "ldw_110", got);

        // Reset in the middle of a refill that memory never answers.
        resp_en = 1'b0;
        @(posedge clk);
        #1;
        reqValid = 1'b1; reqWrite = 1'b0; reqByte = 1'b0; reqAddr = 32'h200;
        repeat (3) @(negedge clk);
        chk("abort_rreq_before", 128'(memReadReq), 128'(1'b1));
        reqValid = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_rreq", 128'(memReadReq), 128'(1'b0));
        chk("abort_stall", 128'(stall), 128'(1'b0));
        chk("abort_raddr", 128'(memReadAddr), 128'(32'h0));
        chk("abort_misses", 128'(missCount), 128'(32'h0));
        ref_mem = bk_mem;
        exp_hits = 0;
        exp_misses = 0;
        @(negedge clk);
        rst = 1'b1;
        resp_en = 1'b1;
        do_op(1'b0, 1'b0, 32'h110, 32'h0, 1 + RdLat, "post_rst_110", got);
        do_op(1'b0, 1'b0, 32'h100, 32'h0, 1 + RdLat, "post_rst_100", got);
        chk("post_rst_100_const", 128'(got), 128'(32'h11111111));

        for (int i = 0; i < 17; i++)
            do_op(tbl[i].w, tbl[i].b, tbl[i].a, tbl[i].wd, tbl[i].stalls,
                  $sformatf("vec%0d", i), got);
        chk("vec16_const", 128'(got), 128'(32'h000000DE));

        // Flush: drop the request mid-miss; the refill must still complete and install.
        @(posedge clk);
        #1;
        reqValid = 1'b1; reqWrite = 1'b0; reqByte = 1'b0; reqAddr = 32'h180;
        @(negedge clk);
        chk("flush_stall0", 128'(stall), 128'(1'b1));
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        exp_misses++;
        fl_stalls = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (!stall) break;
            fl_stalls++;
        end
        chk("flush_stalls", 128'(fl_stalls), 128'(RdLat));
        chk("flush_rvalid", 128'(rDataValid), 128'(1'b0));
        chk("flush_rdata", 128'(rData), 128'(32'h0));
        do_op(1'b0, 1'b0, 32'h180, 32'h0, 0, "flush_rehit", got);

        // Stray response pulses while idle must be ignored.
        @(posedge clk);
        #1;
        inject_stray = 1'b1;
        @(posedge clk);
        #1;
        inject_stray = 1'b0;
        @(negedge clk);
        chk("stray_rreq", 128'(memReadReq), 128'(1'b0));
        chk("stray_stall", 128'(stall), 128'(1'b0));
        do_op(1'b0, 1'b0, 32'h184, 32'h0, 0, "stray_hit", got);

        @(negedge clk);
`ifdef DCACHE_STATS_EN
        chk("hit_count", 128'(hitCount), 128'(exp_hits));
        chk("miss_count", 128'(missCount), 128'(exp_misses));
`else
        chk("hit_count", 128'(hitCount), 128'(32'h0));
        chk("miss_count", 128'(missCount), 128'(32'h0));
`endif
        checks++;
        if (overlap_seen) begin
            failures++;
            $display("FAIL req_overlap: memReadReq and memWriteReq both high, required never");
        end
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
